sdram_cmd_scheduler: RTL and testbench



---
 rtl/sdram_pkg.sv | 43 ++++
 rtl/sdram_sched_stats.sv | 37 +++
 rtl/sdram_cmd_scheduler.sv | 150 +++++++++++++++
 tb/tb_sdram_cmd_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// sdram_pkg
// Shared states, request type and default geometry for the command scheduler.
// Revision: 1.0
// ============================================================================
package sdram_pkg;
  localparam int C_ROW_WIDTH       = 14;
  localparam int C_COL_WIDTH       = 10;
  localparam int C_NUM_GROUPS      = 2;
  localparam int C_BANKS_PER_GROUP = 4;
  localparam int C_BANKS           = C_NUM_GROUPS * C_BANKS_PER_GROUP;
  localparam int C_BANK_W          = $clog2(C_BANKS);
  localparam int C_CNT_W           = 16;

  // Bit positions in the one-hot statistics increment vector
  localparam int C_STAT_HIT        = 0;
  localparam int C_STAT_EMPTY      = 1;
  localparam int C_STAT_CONFLICT   = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PRE,
    ST_PRE_SETTLE,
    ST_WAIT_PRE,
    ST_ACT,
    ST_ACT_SETTLE,
    ST_WAIT_ACT,
    ST_ISSUE,
    ST_CLOSE
  } sched_state_t;

  typedef logic [C_ROW_WIDTH-1:0] bank_row_t;

  typedef struct packed {
    logic                   write;
    logic [C_BANK_W-1:0]    bank;
    bank_row_t              row;
    logic [C_COL_WIDTH-1:0] col;
  } sdram_req_t;
endpackage
`default_nettype wire

// File: rtl/sdram_sched_stats.sv
`default_nettype none
// ============================================================================
// sdram_sched_stats
// Wrapping page-hit / page-empty / page-conflict counters, one-hot increments.
// Revision: 1.0
// ============================================================================
module sdram_sched_stats
  import sdram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         inc,
  output logic [C_CNT_W-1:0] hit_cnt,
  output logic [C_CNT_W-1:0] empty_cnt,
  output logic [C_CNT_W-1:0] conflict_cnt
);
  logic [C_CNT_W-1:0] r_hit;
  logic [C_CNT_W-1:0] r_empty;
  logic [C_CNT_W-1:0] r_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit      <= '0;
      r_empty    <= '0;
      r_conflict <= '0;
    end else begin
      if (inc[C_STAT_HIT])      r_hit      <= r_hit + C_CNT_W'(1);
      if (inc[C_STAT_EMPTY])    r_empty    <= r_empty + C_CNT_W'(1);
      if (inc[C_STAT_CONFLICT]) r_conflict <= r_conflict + C_CNT_W'(1);
    end
  end

  assign hit_cnt      = r_hit;
  assign empty_cnt    = r_empty;
  assign conflict_cnt = r_conflict;
endmodule
`default_nettype wire

// File: rtl/sdram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// sdram_cmd_scheduler
// Single-requester scheduler: precharge/activate as needed, then column command.
// Option: SDRAM_SCHED_AUTO_PRECHARGE_EN selects closed-page policy.
// Revision: 1.0
// ============================================================================
module sdram_cmd_scheduler
  import sdram_pkg::*;
#(
  parameter  int ROW_WIDTH       = C_ROW_WIDTH,
  parameter  int COL_WIDTH       = C_COL_WIDTH,
  parameter  int NUM_GROUPS      = C_NUM_GROUPS,
  parameter  int BANKS_PER_GROUP = C_BANKS_PER_GROUP,
  parameter  int BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
  localparam int BANK_W          = $clog2(BANKS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [BANK_W-1:0]               req_bank,
  input  logic [ROW_WIDTH-1:0]            req_row,
  input  logic [COL_WIDTH-1:0]            req_col,
  input  logic [BANKS-1:0][ROW_WIDTH-1:0] bank_active_row,
  input  logic [BANKS-1:0]                bank_active,
  input  logic [BANKS-1:0]                bank_blocked,
  output logic [BANKS-1:0]                precharge_out,
  output logic [BANKS-1:0]                activate_out,
  output logic [ROW_WIDTH-1:0]            row_address_out,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic                            cmd_write,
  output logic [BANK_W-1:0]               cmd_bank,
  output logic [ROW_WIDTH-1:0]            cmd_row,
  output logic [COL_WIDTH-1:0]            cmd_col,
  output logic [C_CNT_W-1:0]              hit_cnt,
  output logic [C_CNT_W-1:0]              empty_cnt,
  output logic [C_CNT_W-1:0]              conflict_cnt
);
  sched_state_t           r_state;
  sched_state_t           w_next;
  logic                   r_write;
  logic [BANK_W-1:0]      r_bank;
  logic [ROW_WIDTH-1:0]   r_row;
  logic [COL_WIDTH-1:0]   r_col;
  logic [BANKS-1:0]       w_bank_sel;
  logic                   w_blocked;
  logic                   w_open;
  logic                   w_row_hit;
  logic [2:0]             w_inc;

  assign w_bank_sel = BANKS'(1) << r_bank;
  assign w_blocked  = bank_blocked[r_bank];
  assign w_open     = bank_active[r_bank];
  assign w_row_hit  = (bank_active_row[r_bank] == r_row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_write <= req_write;
        r_bank  <= req_bank;
        r_row   <= req_row;
        r_col   <= req_col;
      end
    end
  end

  // Outputs decode from state only, so cmd_ready never reaches cmd_valid.
  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    cmd_valid     = 1'b0;
    precharge_out = '0;
    activate_out  = '0;
    w_inc         = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!w_blocked) begin
          if (w_open && w_row_hit) begin
            w_inc[C_STAT_HIT] = 1'b1;
            w_next            = ST_ISSUE;
          end else if (w_open) begin
            w_inc[C_STAT_CONFLICT] = 1'b1;
            w_next                 = ST_PRE;
          end else begin
            w_inc[C_STAT_EMPTY] = 1'b1;
            w_next              = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        precharge_out = w_bank_sel;
        w_next        = ST_PRE_SETTLE;
      end
      // Settle cycles cover the tracker's one-cycle lag before blocked rises.
      ST_PRE_SETTLE: w_next = ST_WAIT_PRE;
      ST_WAIT_PRE:   if (!w_blocked) w_next = ST_ACT;
      ST_ACT: begin
        activate_out = w_bank_sel;
        w_next       = ST_ACT_SETTLE;
      end
      ST_ACT_SETTLE: w_next = ST_WAIT_ACT;
      ST_WAIT_ACT:   if (!w_blocked) w_next = ST_ISSUE;
      ST_ISSUE: begin
        cmd_valid = 1'b1;
`ifdef SDRAM_SCHED_AUTO_PRECHARGE_EN
        if (cmd_ready) w_next = ST_CLOSE;
`else
        if (cmd_ready) w_next = ST_IDLE;
`endif
      end
`ifdef SDRAM_SCHED_AUTO_PRECHARGE_EN
      ST_CLOSE: begin
        precharge_out = w_bank_sel;
        w_next        = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign row_address_out = r_row;
  assign cmd_write       = r_write;
  assign cmd_bank        = r_bank;
  assign cmd_row         = r_row;
  assign cmd_col         = r_col;

  sdram_sched_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .inc          (w_inc),
    .hit_cnt      (hit_cnt),
    .empty_cnt    (empty_cnt),
    .conflict_cnt (conflict_cnt)
  );
endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_scheduler.sv
`default_nettype none
// tb_sdram_cmd_scheduler: scheduler paired with a behavioural bank tracker (P=5, L=8),
// checked every cycle against a request-level latency/classification model.
module tb_sdram_cmd_scheduler;
  localparam int RW = 14;
  localparam int CW = 10;
  localparam int NB = 8;
  localparam int BW = 3;
  localparam int P = 5;
  localparam int L = 8;
  localparam int TMO = 200;
  localparam int PH_IDLE = 0, PH_LOOK = 1, PH_SCHED = 2, PH_ISS = 3, PH_CLOSE = 4;
`ifdef SDRAM_SCHED_AUTO_PRECHARGE_EN
  localparam bit AUTO_PRE = 1'b1;
`else
  localparam bit AUTO_PRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   req_valid = 1'b0;
  logic                   req_write = 1'b0;
  logic [BW-1:0]          req_bank = '0;
  logic [RW-1:0]          req_row = '0;
  logic [CW-1:0]          req_col = '0;
  logic                   cmd_ready = 1'b0;
  logic                   req_ready, cmd_valid, cmd_write;
  logic [BW-1:0]          cmd_bank;
  logic [RW-1:0]          cmd_row, row_address_out;
  logic [CW-1:0]          cmd_col;
  logic [NB-1:0][RW-1:0]  bank_active_row;
  logic [NB-1:0]          bank_active, bank_blocked, precharge_out, activate_out;
  logic [15:0]            hit_cnt, empty_cnt, conflict_cnt;

  sdram_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .bank_active_row(bank_active_row), .bank_active(bank_active), .bank_blocked(bank_blocked),
    .precharge_out(precharge_out), .activate_out(activate_out), .row_address_out(row_address_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .hit_cnt(hit_cnt), .empty_cnt(empty_cnt), .conflict_cnt(conflict_cnt)
  );

  // Bank tracker: a pulse opens/closes the bank and blocks it for latency+1 cycles.
  int            trk_cnt [NB];
  logic          trk_act [NB];
  logic [RW-1:0] trk_row [NB];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NB; i++) begin
      if (rst) begin
        trk_cnt[i] <= 0;
        trk_act[i] <= 1'b0;
        trk_row[i] <= '0;
      end else if (precharge_out[i]) begin
        trk_act[i] <= 1'b0;
        trk_cnt[i] <= P + 1;
      end else if (activate_out[i]) begin
        trk_act[i] <= 1'b1;
        trk_row[i] <= row_address_out;
        trk_cnt[i] <= L + 1;
      end else if (trk_cnt[i] != 0) begin
        trk_cnt[i] <= trk_cnt[i] - 1;
      end
    end
  end

  always_comb begin
    bank_blocked    = '0;
    bank_active     = '0;
    bank_active_row = '0;
    for (int i = 0; i < NB; i++) begin
      bank_blocked[i]    = (trk_cnt[i] != 0);
      bank_active[i]     = trk_act[i];
      bank_active_row[i] = trk_row[i];
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: no response within %0d cycles (t=%0t)", name, TMO, $time);
  endtask

  // Request-level model: classification from tracked bank state, schedule from latency formulas.
  int            c = 0;
  int            ph = PH_IDLE;
  int            t_pre = -1, t_act = -1, t_valid = -1;
  logic          mw = 1'b0;
  logic [BW-1:0] mb = '0;
  logic [RW-1:0] mr = '0;
  logic [CW-1:0] mc = '0;
  logic [15:0]   m_hit = '0, m_empty = '0, m_conf = '0;

  always @(negedge clk) begin : model_check
    logic [NB-1:0] oh, exp_pre, exp_act;
    int x;
    c = c + 1;
    if (rst) begin
      ph = PH_IDLE; mw = 1'b0; mb = '0; mr = '0; mc = '0;
      t_pre = -1; t_act = -1; t_valid = -1;
      m_hit = '0; m_empty = '0; m_conf = '0;
    end
    oh      = NB'(1) << mb;
    exp_pre = ((ph == PH_CLOSE) || (ph == PH_SCHED && c == t_pre)) ? oh : '0;
    exp_act = (ph == PH_SCHED && c == t_act) ? oh : '0;
    chk("req_ready", 64'(req_ready), 64'(ph == PH_IDLE));
    chk("cmd_valid", 64'(cmd_valid), 64'(ph == PH_ISS));
    chk("precharge_out", 64'(precharge_out), 64'(exp_pre));
    chk("activate_out", 64'(activate_out), 64'(exp_act));
    chk("row_address_out", 64'(row_address_out), 64'(mr));
    chk("cmd_write", 64'(cmd_write), 64'(mw));
    chk("cmd_bank", 64'(cmd_bank), 64'(mb));
    chk("cmd_row", 64'(cmd_row), 64'(mr));
    chk("cmd_col", 64'(cmd_col), 64'(mc));
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
    chk("empty_cnt", 64'(empty_cnt), 64'(m_empty));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
    if (!rst) begin
      case (ph)
        PH_IDLE: if (req_valid) begin
          mw = req_write; mb = req_bank; mr = req_row; mc = req_col;
          ph = PH_LOOK;
        end
        PH_LOOK: if (trk_cnt[mb] == 0) begin
          x = c + 1;
          if (trk_act[mb] && trk_row[mb] == mr) begin
            m_hit = m_hit + 16'd1;
            ph = PH_ISS;
          end else if (trk_act[mb]) begin
            m_conf = m_conf + 16'd1;
            t_pre = x; t_act = x + P + 3; t_valid = x + P + L + 6;
            ph = PH_SCHED;
          end else begin
            m_empty = m_empty + 16'd1;
            t_pre = -1; t_act = x; t_valid = x + L + 3;
            ph = PH_SCHED;
          end
        end
        PH_SCHED: if (c + 1 == t_valid) ph = PH_ISS;
        PH_ISS:   if (cmd_ready) ph = AUTO_PRE ? PH_CLOSE : PH_IDLE;
        PH_CLOSE: ph = PH_IDLE;
        default:  ph = PH_IDLE;
      endcase
    end
  end

  int n_act = 0, n_pre = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (|activate_out)  n_act++;
      if (|precharge_out) n_pre++;
    end
  end

  // lat = edges from the accept edge to the first edge with cmd_valid visible
  task automatic send(input logic wr, input logic [BW-1:0] bk, input logic [RW-1:0] rw,
                      input logic [CW-1:0] cl, input int hold, output int lat);
    int n;
    lat = -1;
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = wr; req_bank = bk; req_row = rw; req_col = cl;
    n = 0;
    while (!req_ready && n < TMO) begin @(posedge clk); #2; n++; end
    if (n >= TMO) begin tmo("accept"); req_valid = 1'b0; return; end
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_bank = BW'($urandom); req_row = RW'($urandom); req_col = CW'($urandom);
    lat = 0;
    do begin @(posedge clk); #2; lat++; end while (!cmd_valid && lat < TMO);
    if (!cmd_valid) begin tmo("cmd_valid"); return; end
    repeat (hold) begin
      @(posedge clk); #2;
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #2;
    cmd_ready = 1'b0;
  endtask

  initial begin : stim
    int lat, a0, p0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_pulses", 64'({precharge_out, activate_out}), 64'd0);
    chk("rst_row_addr", 64'(row_address_out), 64'd0);
    chk("rst_cmd_fields", 64'({cmd_write, cmd_bank, cmd_row, cmd_col}), 64'd0);
    chk("rst_counters", 64'({hit_cnt, empty_cnt, conflict_cnt}), 64'd0);
    rst = 1'b0;

`ifndef SDRAM_SCHED_AUTO_PRECHARGE_EN
    a0 = n_act; p0 = n_pre;
    send(1'b0, 3'd2, 14'h10, 10'h33, 0, lat);
    @(negedge clk); #1;
    chk("empty_latency", 64'(lat), 64'd12);
    chk("empty_count", 64'(empty_cnt), 64'd1);
    chk("empty_cmd_row", 64'(cmd_row), 64'h10);
    chk("empty_pulses", 64'({n_act - a0, n_pre - p0}), {32'd1, 32'd0});

    a0 = n_act; p0 = n_pre;
    send(1'b0, 3'd2, 14'h10, 10'h34, 0, lat);
    @(negedge clk); #1;
    chk("hit_latency", 64'(lat), 64'd1);
    chk("hit_count", 64'(hit_cnt), 64'd1);
    chk("hit_pulses", 64'({n_act - a0, n_pre - p0}), 64'd0);

    a0 = n_act; p0 = n_pre;
    send(1'b1, 3'd2, 14'h20, 10'h35, 10, lat);
    @(negedge clk); #1;
    chk("conflict_latency", 64'(lat), 64'd20);
    chk("conflict_count", 64'(conflict_cnt), 64'd1);
    chk("conflict_pulses", 64'({n_act - a0, n_pre - p0}), {32'd1, 32'd1});
`else
    a0 = n_act; p0 = n_pre;
    send(1'b0, 3'd1, 14'h5, 10'h11, 0, lat);
    @(negedge clk); #1;
    chk("ap_first_latency", 64'(lat), 64'd12);
    chk("ap_first_empty", 64'(empty_cnt), 64'd1);
    chk("ap_first_pulses", 64'({n_act - a0, n_pre - p0}), {32'd1, 32'd1});
    p0 = n_pre;
    send(1'b0, 3'd1, 14'h5, 10'h12, 0, lat);
    @(negedge clk); #1;
    chk("ap_second_empty", 64'(empty_cnt), 64'd2);
    chk("ap_hit_zero", 64'(hit_cnt), 64'd0);
    chk("ap_second_close", 64'(n_pre - p0), 64'd1);
`endif

    // Abort a fresh-bank request while it waits out the activate window.
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b0; req_bank = 3'd5; req_row = 14'h9; req_col = 10'h1;
    while (!req_ready) begin @(posedge clk); #2; end
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("abort_pulses", 64'({precharge_out, activate_out}), 64'd0);
    chk("abort_fields", 64'({row_address_out, cmd_bank, cmd_col}), 64'd0);
    chk("abort_counters", 64'({hit_cnt, empty_cnt, conflict_cnt}), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    send(1'b0, 3'd5, 14'h9, 10'h2, 0, lat);
    @(negedge clk); #1;
    chk("reclass_latency", 64'(lat), 64'd12);
    chk("reclass_empty", 64'(empty_cnt), 64'd1);
    chk("reclass_hit", 64'(hit_cnt), 64'd0);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(1'($urandom), BW'($urandom_range(0, NB - 1)), RW'($urandom_range(0, 2)),
           CW'($urandom), $urandom_range(0, 3), lat);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire
